// File: rtl/bcd_pkg.sv
// Shared definitions for the packed-BCD arithmetic blocks.
// Holds the digit width, the largest legal digit, the sequencer state type,
// and a digit-validity helper used by the optional operand check.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX     = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // A nibble is a legal BCD digit only in the range 0..9.
    function automatic logic bcd_digit_valid(input logic [BCD_DIGIT_W-1:0] d);
        return (d <= BCD_DIGIT_W'(BCD_MAX));
    endfunction

endpackage

// File: rtl/bcd_add_row.sv
// Ripple row of packed-BCD digit adders, carry-in fixed at 0.
// Ports: a, b (DIGITS packed BCD digits each), sum (same width), cout (carry out of the top digit).
// Purely combinational; each digit adds a + b + cin and applies +6 correction when the raw sum exceeds 9.
module bcd_add_row
    import bcd_pkg::*;
#(
    parameter int DIGITS = 5
) (
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
    output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
    output logic                          cout
);

    logic                 carry;
    logic [BCD_DIGIT_W:0] raw;

    always_comb begin
        carry = 1'b0;
        raw   = '0;
        sum   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            raw = {1'b0, a[i*BCD_DIGIT_W +: BCD_DIGIT_W]}
                + {1'b0, b[i*BCD_DIGIT_W +: BCD_DIGIT_W]}
                + {{BCD_DIGIT_W{1'b0}}, carry};
            // Sums above 9 skip the six unused codes and carry into the next digit.
            if (raw > (BCD_DIGIT_W+1)'(BCD_MAX)) begin
                raw   = raw + (BCD_DIGIT_W+1)'(6);
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            sum[i*BCD_DIGIT_W +: BCD_DIGIT_W] = raw[BCD_DIGIT_W-1:0];
        end
        cout = carry;
    end

endmodule

// File: rtl/bcd_seq_mult.sv
// Sequential DIGITS x DIGITS packed-BCD multiplier (repeated addition, one digit shift per multiplier digit).
// Ports: in_clk/in_rst, in_start + in_a/in_b operands, out_busy (CALC), out_done (1-cycle pulse), out_p product, out_err.
// Latency: sum of multiplier digits + DIGITS cycles; optional operand check under BCD_SEQ_MULT_INPUT_CHECK_EN.
module bcd_seq_mult
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                          in_clk,
    input  logic                          in_rst,
    input  logic                          in_start,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] in_a,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] in_b,
    output logic                          out_busy,
    output logic                          out_done,
    output logic [2*BCD_DIGIT_W*DIGITS-1:0] out_p,
    output logic                          out_err
);

    localparam int AW   = BCD_DIGIT_W * DIGITS;
    localparam int PW   = 2 * AW;
    localparam int RW   = BCD_DIGIT_W * (DIGITS + 1);
    localparam int ACCW = BCD_DIGIT_W * (2 * DIGITS + 1);
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t                 state, state_nxt;
    logic [AW-1:0]          a_reg;
    logic [AW-1:0]          b_reg;
    logic [ACCW-1:0]        acc;
    logic [BCD_DIGIT_W-1:0] cnt;
    logic [IDXW-1:0]        idx;
    logic                   start_acc;
    logic                   last_digit;
    logic                   input_bad;
    logic [RW-1:0]          row_sum;
    logic                   row_cout;

    assign start_acc  = in_start && (state != CALC);
    assign last_digit = (idx == IDXW'(DIGITS - 1));

`ifdef BCD_SEQ_MULT_INPUT_CHECK_EN
    logic err_q;

    always_comb begin
        input_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_digit_valid(in_a[i*BCD_DIGIT_W +: BCD_DIGIT_W]) ||
                !bcd_digit_valid(in_b[i*BCD_DIGIT_W +: BCD_DIGIT_W]))
                input_bad = 1'b1;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst)
            err_q <= 1'b0;
        else if (start_acc)
            err_q <= input_bad;
    end

    assign out_err = err_q;
`else
    assign input_bad = 1'b0;
    assign out_err   = 1'b0;
`endif

    // The multiplicand is always added into the upper DIGITS+1 digits; the
    // right shift after each multiplier digit walks partial products down.
    bcd_add_row #(
        .DIGITS (DIGITS + 1)
    ) u_add_row (
        .a    (acc[ACCW-1 -: RW]),
        .b    ({{BCD_DIGIT_W{1'b0}}, a_reg}),
        .sum  (row_sum),
        .cout (row_cout)
    );

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        out_busy  = (state == CALC);
        out_done  = (state == DONE);
        case (state)
            IDLE, DONE: begin
                if (in_start)
                    state_nxt = input_bad ? DONE : CALC;
                else
                    state_nxt = IDLE;
            end
            CALC: begin
                if ((cnt == '0) && last_digit)
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            idx   <= '0;
            out_p <= '0;
        end else if (start_acc) begin
            a_reg <= in_a;
            b_reg <= in_b;
            acc   <= '0;
            cnt   <= in_b[BCD_DIGIT_W-1:0];
            idx   <= '0;
            // A rejected operand pair reports a zero product.
            if (input_bad)
                out_p <= '0;
        end else if (state == CALC) begin
            if (cnt != '0) begin
                acc[ACCW-1 -: RW] <= row_sum;
                cnt               <= cnt - 1'b1;
            end else begin
                acc <= acc >> BCD_DIGIT_W;
                if (last_digit) begin
                    // Low 2N digits of the shifted accumulator; its top digit is zero here.
                    out_p <= acc[BCD_DIGIT_W +: PW];
                end else begin
                    idx <= idx + 1'b1;
                    cnt <= b_reg[BCD_DIGIT_W*(int'(idx)+1) +: BCD_DIGIT_W];
                end
            end
        end
    end

`ifndef SYNTHESIS
    // The accumulator never reaches 10^(2N+1), so a carry out of the row is a logic bug.
    always_ff @(posedge in_clk) begin
        if (!in_rst && (state == CALC) && (cnt != '0))
            assert (!row_cout) else $error("bcd_seq_mult: unexpected carry out of adder row");
    end
`endif

endmodule

// File: tb/tb_bcd_seq_mult.sv
// Directed self-checking bench for bcd_seq_mult with DIGITS=4.
// Drives inputs at 1 time unit after the rising edge and samples there too.
// Covers products, latency, busy/done behaviour, ignored restarts, restart in DONE, async reset and operand checking.
module tb_bcd_seq_mult;

    logic        in_clk;
    logic        in_rst;
    logic        in_start;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_busy;
    logic        out_done;
    logic [31:0] out_p;
    logic        out_err;

    int nvec  = 0;
    int nfail = 0;
    int lowcnt;

    bcd_seq_mult #(
        .DIGITS (4)
    ) dut (
        .in_clk   (in_clk),
        .in_rst   (in_rst),
        .in_start (in_start),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_busy (out_busy),
        .out_done (out_done),
        .out_p    (out_p),
        .out_err  (out_err)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands with in_start high for one edge (E0); returns 1 unit after E0.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        in_start = 1'b1;
        in_a     = a;
        in_b     = b;
        @(posedge in_clk);
        #1;
        in_start = 1'b0;
    endtask

    // Count edges until out_done, starting from k0 edges after E0; then check latency and result.
    task automatic wait_done(input string tag, input int k0, input int exp_l, input logic [31:0] exp_p);
        int k;
        int busy_low;
        k        = k0;
        busy_low = 0;
        while (!out_done && k < 500) begin
            if (!out_busy) busy_low++;
            @(posedge in_clk);
            #1;
            k++;
        end
        check({tag, "_lat"}, 32'(k), 32'(exp_l));
        check({tag, "_p"}, out_p, exp_p);
        check({tag, "_busy"}, 32'(busy_low), 32'd0);
        check({tag, "_err"}, {31'd0, out_err}, 32'd0);
    endtask

    initial begin
        in_rst   = 1'b1;
        in_start = 1'b0;
        in_a     = '0;
        in_b     = '0;
        repeat (2) @(posedge in_clk);
        #1;
        check("rst_busy", {31'd0, out_busy}, 32'd0);
        check("rst_done", {31'd0, out_done}, 32'd0);
        check("rst_p", out_p, 32'd0);
        check("rst_err", {31'd0, out_err}, 32'd0);
        in_rst = 1'b0;
        @(posedge in_clk);
        #1;

        // 1234 x 5678 = 7006652, L = 5+6+7+8 + 4
        start_op(16'h1234, 16'h5678);
        check("m1_busy_e0", {31'd0, out_busy}, 32'd1);
        wait_done("m1", 0, 30, 32'h07006652);

        // Done is a single-cycle pulse and the product is held afterwards.
        @(posedge in_clk);
        #1;
        check("m1_done_pulse", {31'd0, out_done}, 32'd0);
        repeat (3) @(posedge in_clk);
        #1;
        check("m1_hold", out_p, 32'h07006652);

        // 9999 x 9999, worst-case latency 40.
        start_op(16'h9999, 16'h9999);
        wait_done("m2", 0, 40, 32'h99980001);
        @(posedge in_clk);
        #1;

        // Zero operands: only the four shifts.
        start_op(16'h0000, 16'h0000);
        wait_done("m3", 0, 4, 32'h00000000);
        @(posedge in_clk);
        #1;

        start_op(16'h9999, 16'h0001);
        wait_done("m4", 0, 5, 32'h00009999);
        @(posedge in_clk);
        #1;

        // Restart attempt during CALC is ignored.
        start_op(16'h1234, 16'h5678);
        repeat (3) @(posedge in_clk);
        #1;
        start_op(16'h1111, 16'h1111);
        wait_done("m5_ign", 4, 30, 32'h07006652);

        // Start presented in the DONE cycle is accepted: 0002 x 0003, L = 3+4.
        start_op(16'h0002, 16'h0003);
        check("m6_busy_next", {31'd0, out_busy}, 32'd1);
        wait_done("m6", 0, 7, 32'h00000006);
        @(posedge in_clk);
        #1;

        // Asynchronous reset in the middle of a calculation.
        start_op(16'h1234, 16'h5678);
        repeat (10) @(posedge in_clk);
        #2;
        in_rst = 1'b1;
        #1;
        check("ar_busy", {31'd0, out_busy}, 32'd0);
        check("ar_done", {31'd0, out_done}, 32'd0);
        check("ar_p", out_p, 32'd0);
        check("ar_err", {31'd0, out_err}, 32'd0);
        @(posedge in_clk);
        #1;
        in_rst = 1'b0;
        lowcnt = 0;
        repeat (30) begin
            @(posedge in_clk);
            #1;
            if (out_done || out_busy) lowcnt++;
        end
        check("ar_no_done", 32'(lowcnt), 32'd0);

        // Fresh start after the abort: 0025 x 0004 = 100, L = 4+4.
        start_op(16'h0025, 16'h0004);
        wait_done("m7", 0, 8, 32'h00000100);
        @(posedge in_clk);
        #1;

`ifdef BCD_SEQ_MULT_INPUT_CHECK_EN
        // Invalid digit: DONE in the cycle right after the start edge, error flagged, zero product.
        start_op(16'h12A4, 16'h0001);
        check("ck_done", {31'd0, out_done}, 32'd1);
        check("ck_busy", {31'd0, out_busy}, 32'd0);
        check("ck_err", {31'd0, out_err}, 32'd1);
        check("ck_p", out_p, 32'd0);
        @(posedge in_clk);
        #1;
        start_op(16'h0003, 16'h0003);
        check("ck_err_clr", {31'd0, out_err}, 32'd0);
        wait_done("ck_ok", 0, 7, 32'h00000009);
`else
        // Without the check an invalid digit just iterates; B=0 makes the product zero.
        start_op(16'h12A4, 16'h0000);
        wait_done("nc", 0, 4, 32'h00000000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
